// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Sequences a wide (4*NIBBLES-bit) addition through one external 4-bit
//   carry-lookahead adder, one nibble per clock, least significant first.
//
// Parameters
//   NIBBLES     number of 4-bit slices (1..16); operand width W = 4*NIBBLES
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       operation request, honoured only while idle
//   op_a, op_b  W-bit operands, captured on an accepted start
//   cin         carry into nibble 0, captured on an accepted start
//   busy        high whenever an operation is in flight or completing
//   done        one-cycle pulse when result/carry_out are fresh
//   result      W-bit sum, held until the next operation completes
//   carry_out   carry out of the top nibble, held with result
//   adder_a     nibble of A driven to the external adder
//   adder_b     nibble of B driven to the external adder
//   adder_cin   running carry driven to the external adder
//   adder_sum   sum nibble returned by the external adder
//   adder_cout  carry returned by the external adder
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic [3:0]             adder_a,
    output logic [3:0]             adder_b,
    output logic                   adder_cin,
    input  logic [3:0]             adder_sum,
    input  logic                   adder_cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       acc;
    logic [W-1:0]       acc_next;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;

    // Sum nibbles enter at the top and shift down, so after NIBBLES steps
    // nibble 0 sits at the bottom of the accumulator.
    generate
        if (NIBBLES == 1) begin : g_acc_single
            assign acc_next = adder_sum;
        end else begin : g_acc_multi
            assign acc_next = {adder_sum, acc[W-1:4]};
        end
    endgenerate

    // Adder is only driven while a nibble is being processed.
    always_comb begin
        adder_a   = 4'h0;
        adder_b   = 4'h0;
        adder_cin = 1'b0;
        if (state == S_RUN) begin
            adder_a   = a_sh[3:0];
            adder_b   = b_sh[3:0];
            adder_cin = c_reg;
        end
    end

    // Sequencer: capture, one nibble per cycle, publish, return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        c_reg <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    c_reg <= adder_cout;
                    cnt   <= cnt + CNT_W'(1);
                    // Only the final nibble updates the visible result.
                    if (cnt == CNT_LAST) begin
                        result    <= acc_next;
                        carry_out <= adder_cout;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: a 4-nibble and a 1-nibble
// instance, each around a behavioural 4-bit adder, compared against plain
// integer addition.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- NIBBLES=4 instance ----------------
    logic        start, cin, busy, done, carry_out;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_cout;

    assign {adder_cout, adder_sum} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

    nibble_serial_adder #(.NIBBLES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    // ---------------- NIBBLES=1 instance ----------------
    logic        start1, cin1, busy1, done1, carry_out1;
    logic [3:0]  op_a1, op_b1, result1;
    logic [3:0]  adder_a1, adder_b1, adder_sum1;
    logic        adder_cin1, adder_cout1;

    assign {adder_cout1, adder_sum1} = 5'(adder_a1) + 5'(adder_b1) + 5'(adder_cin1);

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
        .busy(busy1), .done(done1), .result(result1), .carry_out(carry_out1),
        .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
        .adder_sum(adder_sum1), .adder_cout(adder_cout1)
    );

    // Last published values, used to check that result never shows partials.
    logic [15:0] prev_res;
    logic        prev_co;
    logic [3:0]  prev_res1;
    logic        prev_co1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full operation on the 4-nibble instance, checked against a+b+c.
    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] full;
        int edges;
        full = 17'(a) + 17'(b) + 17'(c);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 20) begin
            if (edges < 4) begin
                check("drive_a", 32'(adder_a), 32'(4'(a >> (4 * edges))));
                check("drive_b", 32'(adder_b), 32'(4'(b >> (4 * edges))));
            end
            check("hold_result", 32'(result), 32'(prev_res));
            check("hold_carry", 32'(carry_out), 32'(prev_co));
            @(posedge clk); #1;
            edges++;
        end
        check("latency4", 32'(edges), 32'd4);
        check("result4", 32'(result), 32'(full[15:0]));
        check("carry4", 32'(carry_out), 32'(full[16]));
        check("done_cycle_drive", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        prev_res = full[15:0];
        prev_co  = full[16];
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("result_held", 32'({carry_out, result}), 32'(full));
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] full;
        int edges;
        full = 5'(a) + 5'(b) + 5'(c);
        @(negedge clk);
        op_a1 = a; op_b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        edges = 0;
        while (!done1 && edges < 20) begin
            check("hold_result1", 32'({carry_out1, result1}), 32'({prev_co1, prev_res1}));
            @(posedge clk); #1;
            edges++;
        end
        check("latency1", 32'(edges), 32'd1);
        check("result1", 32'(result1), 32'(full[3:0]));
        check("carry1", 32'(carry_out1), 32'(full[4]));
        prev_res1 = full[3:0];
        prev_co1  = full[4];
        @(posedge clk); #1;
        check("done_width1", 32'(done1), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        rst = 1'b1;
        start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
        prev_res = '0; prev_co = 1'b0; prev_res1 = '0; prev_co1 = 1'b0;
        #12;
        check("reset_outputs", 32'({busy, done, carry_out, result}), 32'd0);
        check("reset_drive", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        check("reset_outputs1", 32'({busy1, done1, carry_out1, result1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations
        do_op4(16'h1234, 16'h4321, 1'b0);
        check("dir_5555", 32'({carry_out, result}), 32'h0_5555);
        do_op4(16'hFFFF, 16'h0001, 1'b0);
        check("dir_ripple", 32'({carry_out, result}), 32'h1_0000);
        do_op4(16'hFFFF, 16'hFFFF, 1'b1);
        check("dir_allones", 32'({carry_out, result}), 32'h1_FFFF);

        // start held high with new operands during RUN must be ignored
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("ign_done", 32'(done), 32'd1);
        check("ign_result", 32'({carry_out, result}), 32'h0_3333);
        @(posedge clk); #1;
        check("ign_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("ign_stay_idle", 32'(busy), 32'd0);
        prev_res = 16'h3333; prev_co = 1'b0;

        // Asynchronous reset in RUN cycle 2 aborts and clears outputs
        do_op4(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'({carry_out, result}), 32'd0);
        check("rst_drive", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0; prev_co = 1'b0; prev_res1 = '0; prev_co1 = 1'b0;
        do_op4(16'h00FF, 16'h0001, 1'b0);
        check("post_rst", 32'({carry_out, result}), 32'h0_0100);

        // Single-nibble instance
        do_op1(4'h9, 4'h8, 1'b0);
        check("n1_dir", 32'({carry_out1, result1}), 32'h11);
        for (int i = 0; i < 20; i++) begin
            do_op1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Random operations, back-to-back
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            do_op4(ra, rb, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
